// File: rtl/i2so_serializer_param_if.sv
// ---------------------------------------------------------------------------
// i2so_serializer_param_if
// Handshake bundle between the filter stage and the I2S-output serializer.
//   filt_i2so_rts : upstream pair valid (filter -> serializer)
//   filt_i2so_lft : left sample, DATA_W bits
//   filt_i2so_rgt : right sample, DATA_W bits
//   filt_i2so_rtr : serializer ready, high while its FIFO is not full
// Modports: master = filter side, slave = serializer side.
// ---------------------------------------------------------------------------
interface i2so_serializer_param_if #(
  parameter int DATA_W = 16
);
  logic              filt_i2so_rts;
  logic [DATA_W-1:0] filt_i2so_lft;
  logic [DATA_W-1:0] filt_i2so_rgt;
  logic              filt_i2so_rtr;

  modport master (
    output filt_i2so_rts,
    output filt_i2so_lft,
    output filt_i2so_rgt,
    input  filt_i2so_rtr
  );

  modport slave (
    input  filt_i2so_rts,
    input  filt_i2so_lft,
    input  filt_i2so_rgt,
    output filt_i2so_rtr
  );
endinterface

// File: rtl/i2so_serializer_param.sv
// ---------------------------------------------------------------------------
// i2so_serializer_param
// Parametrised I2S-output serializer. Stereo pairs arrive over the rts/rtr
// handshake into a FIFO_DEPTH-entry FIFO; each frame start (strobe with k=0)
// pops one pair and shifts it MSB-first, one bit per enabled sck_transition
// strobe, in left-justified or Philips I2S framing (mode latched per frame).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   en                : serializer enable (FIFO keeps accepting when low)
//   i2s_mode          : 1 = I2S (one-bit data delay), 0 = left-justified
//   sck_transition    : one-clk strobe per serial bit period
//   up (slave)        : filt_i2so_rts/lft/rgt in, filt_i2so_rtr out
//   i2so_sd, i2so_ws  : serial data / word select (0 = left)
//   fifo_level        : pairs currently held
//   i2so_underflow    : one-clk pulse at a frame start with an empty FIFO
// Optional (macro I2SO_UNDERFLOW_CNT_EN):
//   underflow_clr     : one-clk clear of the underflow counter
//   underflow_cnt     : saturating count of underflow pulses
// ---------------------------------------------------------------------------
module i2so_serializer_param #(
  parameter int DATA_W     = 16,
  parameter int SLOT_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             i2s_mode,
  input  logic                             sck_transition,
  i2so_serializer_param_if.slave           up,
  output logic                             i2so_sd,
  output logic                             i2so_ws,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             i2so_underflow
`ifdef I2SO_UNDERFLOW_CNT_EN
  ,
  input  logic                             underflow_clr,
  output logic [15:0]                      underflow_cnt
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int KW = $clog2(2 * SLOT_W);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [KW-1:0] K_LAST   = KW'(2 * SLOT_W - 1);
  localparam logic [KW-1:0] K_SLOT   = KW'(SLOT_W);
  localparam logic [KW-1:0] K_DATA   = KW'(DATA_W);

  logic [DATA_W-1:0] mem_l_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_r_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              rtr_q, rtr_d;
  logic [KW-1:0]     k_q, k_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic              sd_q, sd_d, ws_q, ws_d, dly_q, dly_d, uf_q, uf_d;

  logic              strobe_s, frame_start_s, push_s, pop_s;
  logic              cur_mode_s, lj_bit_s;
  logic [DATA_W-1:0] cur_l_s, cur_r_s, slot_s, shifted_s;
  logic [KW-1:0]     p_s;

  // FIFO bookkeeping: push/pop qualification, pointers, exact level, ready
  always_comb begin
    strobe_s      = sck_transition & en;
    frame_start_s = strobe_s & (k_q == '0);
    // rtr_q already reflects full, so a same-cycle pop never frees a slot early
    push_s        = up.filt_i2so_rts & rtr_q;
    pop_s         = frame_start_s & (level_q != '0);
    wr_ptr_d      = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d      = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    rtr_d = (level_d != FULL_LVL);
  end

  // Left-justified bit for the current strobe; frame start uses the fresh pop
  always_comb begin
    if (pop_s) begin
      cur_l_s = mem_l_q[rd_ptr_q];
      cur_r_s = mem_r_q[rd_ptr_q];
    end else if (frame_start_s) begin
      cur_l_s = '0;
      cur_r_s = '0;
    end else begin
      cur_l_s = sh_l_q;
      cur_r_s = sh_r_q;
    end
    cur_mode_s = frame_start_s ? i2s_mode : mode_q;
    if (k_q >= K_SLOT) begin
      slot_s = cur_r_s;
      p_s    = k_q - K_SLOT;
    end else begin
      slot_s = cur_l_s;
      p_s    = k_q;
    end
    shifted_s = slot_s << p_s;
    lj_bit_s  = (p_s < K_DATA) ? shifted_s[DATA_W-1] : 1'b0;
  end

  // Frame engine: counter, shadows, mode latch, serial outputs, underflow
  always_comb begin
    k_d    = k_q;
    mode_d = mode_q;
    sh_l_d = sh_l_q;
    sh_r_d = sh_r_q;
    sd_d   = sd_q;
    ws_d   = ws_q;
    dly_d  = dly_q;
    uf_d   = 1'b0;
    if (!en) begin
      k_d   = '0;
      sd_d  = 1'b0;
      ws_d  = 1'b0;
      dly_d = 1'b0;
    end else if (strobe_s) begin
      k_d    = (k_q == K_LAST) ? '0 : (k_q + KW'(1));
      mode_d = cur_mode_s;
      sh_l_d = cur_l_s;
      sh_r_d = cur_r_s;
      ws_d   = (k_q >= K_SLOT);
      dly_d  = lj_bit_s;
      // I2S emits the previous strobe's left-justified bit
      sd_d   = cur_mode_s ? dly_q : lj_bit_s;
      uf_d   = frame_start_s & (level_q == '0);
    end else begin
      k_d = k_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rtr_q    <= 1'b0;
      k_q      <= '0;
      mode_q   <= 1'b0;
      sh_l_q   <= '0;
      sh_r_q   <= '0;
      sd_q     <= 1'b0;
      ws_q     <= 1'b0;
      dly_q    <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rtr_q    <= rtr_d;
      k_q      <= k_d;
      mode_q   <= mode_d;
      sh_l_q   <= sh_l_d;
      sh_r_q   <= sh_r_d;
      sd_q     <= sd_d;
      ws_q     <= ws_d;
      dly_q    <= dly_d;
      uf_q     <= uf_d;
    end
  end

  // FIFO storage; contents need no reset since pointers gate all reads
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_l_q[wr_ptr_q] <= up.filt_i2so_lft;
      mem_r_q[wr_ptr_q] <= up.filt_i2so_rgt;
    end
  end

`ifdef I2SO_UNDERFLOW_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Saturating underflow counter; clear wins but keeps a same-cycle event
  always_comb begin
    if (underflow_clr) begin
      ucnt_d = uf_d ? 16'd1 : 16'd0;
    end else if (uf_d && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end else begin
      ucnt_d = ucnt_q;
    end
  end

  // Underflow counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      ucnt_q <= 16'd0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underflow_cnt = ucnt_q;
`endif

  assign up.filt_i2so_rtr = rtr_q;
  assign i2so_sd          = sd_q;
  assign i2so_ws          = ws_q;
  assign fifo_level       = level_q;
  assign i2so_underflow   = uf_q;

endmodule

// File: tb/tb_i2so_serializer_param.sv
// ---------------------------------------------------------------------------
// tb_i2so_serializer_param
// Directed bench for two serializer instances sharing control inputs:
//   dut_a : DATA_W=16, SLOT_W=16, FIFO_DEPTH=4
//   dut_b : DATA_W=24, SLOT_W=32, FIFO_DEPTH=4
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_i2so_serializer_param;

  logic clk, rst, en, mode, sck, clr;
  logic sd_a, ws_a, uf_a, sd_b, ws_b, uf_b;
  logic [2:0] lvl_a, lvl_b;
  logic [15:0] cnt_a, cnt_b;
  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_lj;
  logic [31:0] exp_i2s;
  logic [63:0] exp_b;

  i2so_serializer_param_if #(.DATA_W(16)) ifa ();
  i2so_serializer_param_if #(.DATA_W(24)) ifb ();

  i2so_serializer_param #(.DATA_W(16), .SLOT_W(16), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .en(en), .i2s_mode(mode), .sck_transition(sck),
    .up(ifa), .i2so_sd(sd_a), .i2so_ws(ws_a), .fifo_level(lvl_a),
    .i2so_underflow(uf_a)
`ifdef I2SO_UNDERFLOW_CNT_EN
    , .underflow_clr(clr), .underflow_cnt(cnt_a)
`endif
  );

  i2so_serializer_param #(.DATA_W(24), .SLOT_W(32), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .en(en), .i2s_mode(mode), .sck_transition(sck),
    .up(ifb), .i2so_sd(sd_b), .i2so_ws(ws_b), .fifo_level(lvl_b),
    .i2so_underflow(uf_b)
`ifdef I2SO_UNDERFLOW_CNT_EN
    , .underflow_clr(clr), .underflow_cnt(cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one enabled strobe; returns at the falling edge after it took effect
  task automatic strobe();
    sck = 1'b1;
    @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic push_a(input logic [15:0] l, input logic [15:0] r);
    ifa.filt_i2so_rts = 1'b1;
    ifa.filt_i2so_lft = l;
    ifa.filt_i2so_rgt = r;
    @(negedge clk);
    ifa.filt_i2so_rts = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; sck = 1'b0; clr = 1'b0;
    ifa.filt_i2so_rts = 1'b0; ifa.filt_i2so_lft = 16'h0; ifa.filt_i2so_rgt = 16'h0;
    ifb.filt_i2so_rts = 1'b0; ifb.filt_i2so_lft = 24'h0; ifb.filt_i2so_rgt = 24'h0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_sd", sd_a, 1'b0);
    chk("rst_ws", ws_a, 1'b0);
    chk("rst_uf", uf_a, 1'b0);
    chk("rst_lvl", lvl_a, 3'd0);
    chk("rst_rtr", ifa.filt_i2so_rtr, 1'b0);
    rst = 1'b0; en = 1'b1;
    @(negedge clk);
    chk("rtr_after_rst", ifa.filt_i2so_rtr, 1'b1);

    // 1: left-justified 16/16 frame
    push_a(16'hFF00, 16'h00FF);
    chk("t1_lvl_push", lvl_a, 3'd1);
    exp_lj = 32'b1111111100000000_0000000011111111;
    for (int j = 0; j < 32; j++) begin
      strobe();
      chk("t1_sd", sd_a, exp_lj[31-j]);
      chk("t1_ws", ws_a, (j >= 16) ? 1'b1 : 1'b0);
      if (j == 0) begin
        chk("t1_uf", uf_a, 1'b0);
        chk("t1_lvl_pop", lvl_a, 3'd0);
      end
    end
    chk("t1_rtr", ifa.filt_i2so_rtr, 1'b1);

    // 2: I2S mode, enable toggled so the first bit is 0
    en = 1'b0; mode = 1'b1;
    @(negedge clk);
    chk("en_low_sd", sd_a, 1'b0);
    chk("en_low_ws", ws_a, 1'b0);
    en = 1'b1;
    push_a(16'hFF00, 16'h00FF);
    exp_i2s = {1'b0, exp_lj[31:1]};
    for (int j = 0; j < 32; j++) begin
      strobe();
      chk("t2_sd", sd_a, exp_i2s[31-j]);
      chk("t2_ws", ws_a, (j >= 16) ? 1'b1 : 1'b0);
    end

    // 3: 24-bit data in 32-bit slots, left-justified
    en = 1'b0; mode = 1'b0;
    @(negedge clk);
    en = 1'b1;
    ifb.filt_i2so_rts = 1'b1; ifb.filt_i2so_lft = 24'hABCDEF; ifb.filt_i2so_rgt = 24'h123456;
    @(negedge clk);
    ifb.filt_i2so_rts = 1'b0;
    chk("t3_lvl", lvl_b, 3'd1);
    exp_b = {24'hABCDEF, 8'h00, 24'h123456, 8'h00};
    for (int j = 0; j < 64; j++) begin
      strobe();
      chk("t3_sd", sd_b, exp_b[63-j]);
      chk("t3_ws", ws_b, (j >= 32) ? 1'b1 : 1'b0);
    end

    // 5: empty FIFO underflow over three frames
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
`ifdef I2SO_UNDERFLOW_CNT_EN
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t5_cnt_clr", cnt_a, 16'd0);
`endif
    for (int j = 0; j < 96; j++) begin
      strobe();
      chk("t5_uf", uf_a, ((j % 32) == 0) ? 1'b1 : 1'b0);
      chk("t5_sd", sd_a, 1'b0);
    end
    @(negedge clk);
    chk("t5_uf_idle", uf_a, 1'b0);
`ifdef I2SO_UNDERFLOW_CNT_EN
    chk("t5_cnt3", cnt_a, 16'd3);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t5_cnt_clr2", cnt_a, 16'd0);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    clr = 1'b1;
    strobe();
    clr = 1'b0;
    chk("t5_clr_and_uf", cnt_a, 16'd1);
`endif

    // 6: reset mid-frame at k=20 with two pairs left
    en = 1'b0; mode = 1'b0;
    @(negedge clk);
    push_a(16'hFF00, 16'hFFFF);
    push_a(16'hFF00, 16'hFFFF);
    push_a(16'hFF00, 16'hFFFF);
    chk("t6_lvl3", lvl_a, 3'd3);
    en = 1'b1;
    repeat (20) strobe();
    chk("t6_lvl2", lvl_a, 3'd2);
    chk("t6_sd_pre", sd_a, 1'b1);
    chk("t6_ws_pre", ws_a, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_lvl", lvl_a, 3'd0);
    chk("t6_rst_sd", sd_a, 1'b0);
    chk("t6_rst_ws", ws_a, 1'b0);
    chk("t6_rst_rtr", ifa.filt_i2so_rtr, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rtr_rel", ifa.filt_i2so_rtr, 1'b1);
    push_a(16'hA5A5, 16'h0000);
    chk("t6_lvl_push", lvl_a, 3'd1);
    strobe();
    chk("t6_bit0_sd", sd_a, 1'b1);
    chk("t6_bit0_ws", ws_a, 1'b0);
    chk("t6_bit0_uf", uf_a, 1'b0);
    chk("t6_bit0_lvl", lvl_a, 3'd0);
    strobe();
    chk("t6_bit1_sd", sd_a, 1'b0);

    // 4: fill to full with strobes stopped, then one frame start frees a slot
    en = 1'b0;
    @(negedge clk);
    ifa.filt_i2so_rts = 1'b1; ifa.filt_i2so_lft = 16'h1111; ifa.filt_i2so_rgt = 16'h2222;
    repeat (6) @(negedge clk);
    chk("t4_lvl_full", lvl_a, 3'd4);
    chk("t4_rtr_full", ifa.filt_i2so_rtr, 1'b0);
    en = 1'b1;
    strobe();
    chk("t4_lvl_pop", lvl_a, 3'd3);
    chk("t4_rtr_pop", ifa.filt_i2so_rtr, 1'b1);
    @(negedge clk);
    chk("t4_lvl_fifth", lvl_a, 3'd4);
    chk("t4_rtr_fifth", ifa.filt_i2so_rtr, 1'b0);
    ifa.filt_i2so_rts = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
